// File: rtl/capture_pkg.sv
// Shared types and helpers for the edge event capture block.
// Record layout, vector width and the FIFO level width rule.
package capture_pkg;

    localparam int VEC_W    = 3;
    localparam int TS_W_DEF = 16;

    typedef struct packed {
        logic [VEC_W-1:0]    bits;
        logic [TS_W_DEF-1:0] ts;
    } record_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/edge_event_capture_if.sv
// Record read-out handshake of the edge event capture block.
// The capture block drives the master side, the consumer the slave side.
interface edge_event_capture_if #(
    parameter int TS_W = 16
);
    import capture_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_bits;
    logic [TS_W-1:0]  out_time;

    modport master (
        output out_valid,
        output out_bits,
        output out_time,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_bits,
        input  out_time,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with synchronous flush.
// When empty, the output keeps the last record it presented.
module sync_fifo_fwft
    import capture_pkg::*;
#(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic [W-1:0]              din,
    input  logic                      pop,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] last_q;
    logic         do_push;
    logic         do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= dout;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                last_q <= dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/edge_event_capture.sv
// Timestamps every change of the {w,x,y} lines into a small FIFO.
// Keeps the free-running time base, the previous sample and overflow.
module edge_event_capture
    import capture_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [VEC_W-1:0]          in_bits,
    input  logic                      clear,
    edge_event_capture_if.master      rd,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow
);

    typedef struct packed {
        logic [VEC_W-1:0] bits;
        logic [TS_W-1:0]  ts;
    } rec_t;

    logic [TS_W-1:0]  ts;
    logic [VEC_W-1:0] prev;
    logic             evt;
    logic             full;
    logic             empty;
    rec_t             din;
    rec_t             dout;

    assign evt      = (in_bits != prev);
    assign din.bits = in_bits;
    assign din.ts   = ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= in_bits;
            if (clear) begin
                ts       <= '0;
                overflow <= 1'b0;
            end else begin
                ts <= ts + TS_W'(1);
                if (evt && full && !rd.out_ready)
                    overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .W     ($bits(rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (evt && !clear),
        .din   (din),
        .pop   (rd.out_ready),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign rd.out_valid = !empty;
    assign rd.out_bits  = dout.bits;
    assign rd.out_time  = dout.ts;

endmodule

// File: tb/tb_edge_event_capture.sv
// Scenario bench for edge_event_capture with a record scoreboard.
// A second instance with a 4-bit time base covers wrap-around.
module tb_edge_event_capture;

    typedef struct {
        logic [2:0]  b;
        logic [31:0] t;
    } rec_s;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_bits;
    logic       clear;
    logic [2:0] level1;
    logic [2:0] level2;
    logic       ovf1;
    logic       ovf2;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    rec_s exp_q[$];

    edge_event_capture_if #(.TS_W(16)) bus1 ();
    edge_event_capture_if #(.TS_W(4))  bus2 ();

    edge_event_capture #(.TS_W(16), .DEPTH(4)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bits  (in_bits),
        .clear    (clear),
        .rd       (bus1.master),
        .level    (level1),
        .overflow (ovf1)
    );

    edge_event_capture #(.TS_W(4), .DEPTH(4)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bits  (in_bits),
        .clear    (clear),
        .rd       (bus2.master),
        .level    (level2),
        .overflow (ovf2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic advance_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        in_bits        = 3'b000;
        clear          = 1'b0;
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        exp_q.delete();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic pop_one(input bit sel, input string nm);
        logic        v;
        logic [2:0]  b;
        logic [31:0] t;
        rec_s        e;
        v = sel ? bus2.out_valid : bus1.out_valid;
        b = sel ? bus2.out_bits : bus1.out_bits;
        t = sel ? 32'(bus2.out_time) : 32'(bus1.out_time);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no record expected, valid=%0b", nm, v);
        end else begin
            e = exp_q.pop_front();
            if (v !== 1'b1 || b !== e.b || t !== e.t) begin
                failures++;
                $display("FAIL %s: got v=%0b bits=%b time=%0d want v=1 bits=%b time=%0d",
                         nm, v, b, t, e.b, e.t);
            end
        end
        if (sel) bus2.out_ready = 1'b1;
        else     bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        in_bits        = 3'b101;
        clear          = 1'b0;
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        #1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.out_bits !== 3'b000 ||
            bus1.out_time !== 16'd0 || level1 !== 3'd0 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: v=%0b bits=%b time=%0d lvl=%0d ovf=%0b want all 0",
                     bus1.out_valid, bus1.out_bits, bus1.out_time, level1, ovf1);
        end
    endtask

    task automatic test_idle();
        int seen;
        do_reset();
        bus1.out_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            tick();
            if (bus1.out_valid !== 1'b0) seen++;
        end
        bus1.out_ready = 1'b0;
        checks++;
        if (seen != 0 || level1 !== 3'd0 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL idle: valid_cycles=%0d lvl=%0d ovf=%0b want 0 0 0",
                     seen, level1, ovf1);
        end
    endtask

    task automatic test_schedule();
        do_reset();
        in_bits[2] = 1'b0;
        advance_to(5);
        in_bits[0] = 1'b0;
        advance_to(10);
        in_bits[1] = 1'b1;
        exp_q.push_back('{3'b010, 32'd10});
        advance_to(20);
        in_bits = 3'b010;
        advance_to(23);
        checks++;
        if (level1 !== 3'd1 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL sched_level: lvl=%0d ovf=%0b want 1 0", level1, ovf1);
        end
        pop_one(1'b0, "sched_rec");
        checks++;
        if (bus1.out_valid !== 1'b0 || level1 !== 3'd0) begin
            failures++;
            $display("FAIL sched_extra: v=%0b lvl=%0d want 0 0", bus1.out_valid, level1);
        end
    endtask

    task automatic test_overflow();
        logic [2:0] seq [5];
        seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            advance_to(3 + i);
            in_bits = seq[i];
            if (i < 4) exp_q.push_back('{seq[i], 32'(3 + i)});
        end
        advance_to(9);
        checks++;
        if (level1 !== 3'd4 || ovf1 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full: lvl=%0d ovf=%0b want 4 1", level1, ovf1);
        end
        for (int i = 0; i < 4; i++) pop_one(1'b0, "ovf_pop");
        checks++;
        if (bus1.out_valid !== 1'b0 || level1 !== 3'd0 ||
            bus1.out_bits !== 3'b110 || bus1.out_time !== 16'd6 || ovf1 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_after: v=%0b lvl=%0d bits=%b time=%0d ovf=%0b want 0 0 110 6 1",
                     bus1.out_valid, level1, bus1.out_bits, bus1.out_time, ovf1);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2:0] seq [4];
        seq = '{3'b001, 3'b011, 3'b111, 3'b110};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            advance_to(1 + i);
            in_bits = seq[i];
            exp_q.push_back('{seq[i], 32'(1 + i)});
        end
        advance_to(6);
        checks++;
        if (level1 !== 3'd4 || bus1.out_bits !== exp_q[0].b ||
            32'(bus1.out_time) !== exp_q[0].t) begin
            failures++;
            $display("FAIL fpp_head: lvl=%0d bits=%b time=%0d want 4 %b %0d",
                     level1, bus1.out_bits, bus1.out_time, exp_q[0].b, exp_q[0].t);
        end
        in_bits        = 3'b100;
        bus1.out_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back('{3'b100, 32'd6});
        tick();
        bus1.out_ready = 1'b0;
        checks++;
        if (level1 !== 3'd4 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL fpp_level: lvl=%0d ovf=%0b want 4 0", level1, ovf1);
        end
        for (int i = 0; i < 4; i++) pop_one(1'b0, "fpp_pop");
    endtask

    task automatic test_wrap();
        do_reset();
        advance_to(14);
        in_bits = 3'b001;
        exp_q.push_back('{3'b001, 32'(14 % 16)});
        advance_to(17);
        in_bits = 3'b011;
        exp_q.push_back('{3'b011, 32'(17 % 16)});
        advance_to(19);
        checks++;
        if (level2 !== 3'd2) begin
            failures++;
            $display("FAIL wrap_level: lvl=%0d want 2", level2);
        end
        pop_one(1'b1, "wrap_pop");
        pop_one(1'b1, "wrap_pop");
    endtask

    task automatic test_clear_reset();
        logic [2:0] seq [5];
        int         cclr;
        int         seen;
        seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            advance_to(1 + i);
            in_bits = seq[i];
            if (i < 4) exp_q.push_back('{seq[i], 32'(1 + i)});
        end
        advance_to(7);
        pop_one(1'b0, "clr_pop");
        checks++;
        if (level1 !== 3'd3 || ovf1 !== 1'b1) begin
            failures++;
            $display("FAIL clr_pre: lvl=%0d ovf=%0b want 3 1", level1, ovf1);
        end
        cclr    = cyc;
        clear   = 1'b1;
        in_bits = 3'b000;
        tick();
        clear = 1'b0;
        exp_q.delete();
        checks++;
        if (level1 !== 3'd0 || ovf1 !== 1'b0 || bus1.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_post: lvl=%0d ovf=%0b v=%0b want 0 0 0",
                     level1, ovf1, bus1.out_valid);
        end
        seen = 0;
        repeat (2) begin
            tick();
            if (bus1.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL clr_coincident: valid_cycles=%0d want 0", seen);
        end
        in_bits = 3'b010;
        exp_q.push_back('{3'b010, 32'(cyc - cclr - 1)});
        tick();
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_bits !== exp_q[0].b ||
            32'(bus1.out_time) !== exp_q[0].t) begin
            failures++;
            $display("FAIL clr_ts: v=%0b bits=%b time=%0d want 1 %b %0d",
                     bus1.out_valid, bus1.out_bits, bus1.out_time, exp_q[0].b, exp_q[0].t);
        end
        bus1.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus1.out_valid !== 1'b0 || bus1.out_bits !== 3'b000 ||
            bus1.out_time !== 16'd0 || level1 !== 3'd0 || ovf1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_midpop: v=%0b bits=%b time=%0d lvl=%0d ovf=%0b want all 0",
                     bus1.out_valid, bus1.out_bits, bus1.out_time, level1, ovf1);
        end
        bus1.out_ready = 1'b0;
        exp_q.delete();
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_schedule();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_clear_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
- Receiving end of the timed bit-stimulus sequences our stimulus modules drive onto three single-bit lines (w, x, y).
- Samples the three lines every clock and detects any change in the 3-bit vector.
- Stores each change as a {vector, timestamp} record in a small FIFO, read out through a valid/ready interface.
- Benches use it to check the scheduled sequences (values and relative delays) without hand-reading waveforms.

Parameters:
- TS_W, 16: timestamp counter width.
- DEPTH, 4: FIFO depth in records; must be a power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bits  input  3  monitored lines {w,x,y}. Bit 2 = w. Synchronous to clk.
- clear  input  1  synchronous flush, one-cycle pulse.
- out_valid  output  1  FIFO head record is available.
- out_ready  input  1  consumer accepts the head record.
- out_bits  output  3  vector value of the head record.
- out_time  output  TS_W  timestamp of the head record.
- level  output  clog2(DEPTH)+1  number of stored records.
- overflow  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset state (rst_n low, takes effect immediately, asynchronously):
  - ts counter = 0, prev = 3'b000.
  - FIFO empty: out_valid = 0, out_bits = 0, out_time = 0, level = 0.
  - overflow = 0.
- Timestamp: ts increments by 1 on every clock edge while out of reset and wraps from 2^TS_W-1 to 0. No saturation.
- Event detection: at each rising edge, event = (in_bits != prev). prev <= in_bits on every edge.
  - A nonzero in_bits at the first edge after reset is an event, because prev resets to 0.
- Push: on an event edge, the record {in_bits, ts} is written, where ts is the pre-increment value at that edge.
  - Latency: out_valid rises in the cycle after the push edge when the FIFO was empty.
  - The FIFO is first-word-fall-through: out_bits and out_time show the head record whenever out_valid = 1.
- Pop: happens at an edge where out_valid && out_ready.
  - When out_valid = 0, out_bits and out_time hold their last value.
- Full, with a push and no pop at the same edge: the record is dropped and overflow <= 1. overflow stays 1 until clear or reset.
- Full, with a push and a pop at the same edge: both are performed, level stays DEPTH, overflow is unchanged.
- Empty, with a push at an edge: no pop occurs at that edge (out_valid was 0). The record appears next cycle.
- Pointers wrap modulo DEPTH. level = write count minus read count, range 0..DEPTH.
- clear (synchronous, takes priority over push and pop at the same edge):
  - FIFO emptied, ts <= 0, overflow <= 0, prev <= in_bits.
  - A change coinciding with clear is therefore not recorded.
- Reset mid-operation: all records are lost, everything returns to the reset state; no partial pop is visible.

Decomposition:
- Shared package `capture_pkg`:
  - record typedef with fields bits[2:0] and time[TS_W-1:0], TS_W default.
  - constant VEC_W = 3.
  - function that computes level width from DEPTH.
- One natural sub-module, `sync_fifo_fwft`:
  - parameterised width/depth, asynchronous active-low reset.
  - push/pop/full/empty/level ports.
  - Top level keeps the ts counter, prev register, event logic, overflow and clear.

Test Plan:
1. Release reset with in_bits = 000 held for 30 cycles, out_ready = 1 -> out_valid never asserts, level = 0, overflow = 0.
2. Schedule from reset release: w = 0 at cycle 0, x = 1 at cycle 10, y = 0 at cycle 5, then the packed vector rechecked at cycle 20; out_ready = 0 -> level = 1 with one record {010, 10}; no records for cycles 5 or 20.
3. Drive changes 001, 011, 111, 110, 100 at cycles 3, 4, 5, 6, 7 (DEPTH = 4), out_ready = 0 -> level = 4 and overflow = 1. Then pop all four -> records {001,3}, {011,4}, {111,5}, {110,6} in that order.
4. FIFO full; a change and out_ready = 1 at the same edge -> level stays 4, overflow stays 0, the new record becomes the tail, the old head is removed.
5. Set TS_W = 4; change in_bits at cycles 14 and 17 -> out_time = 14, then 1 (wrap-around).
6. Hold 3 records and overflow = 1; pulse clear together with an in_bits change -> next cycle level = 0, overflow = 0, out_valid = 0; the coincident change is not recorded. Pull rst_n low mid-pop -> all outputs return to their reset values immediately.
